// File: rtl/fifo_host_pkg.sv
// Shared types and pin encodings for the pin-level FIFO host master.
package fifo_host_pkg;

    typedef enum logic [1:0] {
        OP_DEV_RESET = 2'd0,
        OP_PUSH      = 2'd1,
        OP_POP       = 2'd2,
        OP_PEEK      = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_RST,
        ST_INIT,
        ST_INIT_HI,
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_RESP
    } state_e;

    localparam int PIN_CLK   = 0;
    localparam int PIN_MODE  = 1;
    localparam int PIN_RST_N = 2;
    localparam int PIN_POP   = 3;

    localparam logic [7:0] PAT_IDLE  = 8'h04;
    localparam logic [7:0] PAT_RESET = 8'h00;

    // Device pin pattern for an op with the generated clock bit left low.
    function automatic logic [7:0] op_pattern(op_e op, logic [5:0] data, logic [3:0] peek);
        logic [7:0] p;
        p = PAT_RESET;
        case (op)
            OP_PUSH: begin
                p[PIN_MODE] = 1'b1;
                p[7:2]      = data;
            end
            OP_POP: begin
                p[PIN_RST_N] = 1'b1;
                p[PIN_POP]   = 1'b1;
            end
            OP_PEEK: begin
                p[PIN_RST_N] = 1'b1;
                p[7:4]       = peek;
            end
            default: p = PAT_RESET;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/fifo_pin_host_if.sv
// Command/response handshake bundle between test logic (master) and the FIFO pin host (slave).
interface fifo_pin_host_if #(parameter int DW = 6);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic [3:0]    cmd_peek;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_empty_n;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_peek, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_empty_n, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_peek, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_empty_n, rsp_err
    );
endinterface

// File: rtl/fifo_host_phase_cnt.sv
// Device-clock phase timer: start loads a down-counter, done flags its terminal count.
module fifo_host_phase_cnt #(
    parameter int HALF_PER = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);
    localparam int CW = $clog2(HALF_PER + 1);

    logic [CW-1:0] cnt_q;
    logic          run_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            cnt_q <= CW'(HALF_PER - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) run_q <= 1'b0;
            else             cnt_q <= cnt_q - CW'(1);
        end
    end

    assign done = run_q && (cnt_q == '0);
endmodule

// File: rtl/fifo_pin_host.sv
// Host master for the pin-level FIFO device: command/response in, device pin sequences out.
// Optional FIFO_HOST_ECHO_CHECK_EN: at capture the device must echo ~clk (io_out[0]==0).
//   state      | meaning
//   ST_RST     | reset held; pins IDLE, clock low
//   ST_INIT    | RESET pattern, clock low
//   ST_INIT_HI | RESET pattern, clock high
//   ST_IDLE    | IDLE pattern, waiting for a command
//   ST_SETUP   | op pattern, clock low
//   ST_HIGH    | op pattern, clock high; capture on last cycle
//   ST_RESP    | response held until rsp_ready
module fifo_pin_host
    import fifo_host_pkg::*;
#(
    parameter  int HALF_PER = 2,
    parameter  int DW       = 6,
    parameter  int DEPTH    = 16,
    localparam int LW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    fifo_pin_host_if.slave host,
    output logic [LW-1:0] level,
    output logic          desync,
    output logic [7:0]    dev_io_in,
    input  logic [7:0]    dev_io_out
);
    state_e        state_q, state_d;
    op_e           op_q;
    logic [DW-1:0] data_q;
    logic [3:0]    peek_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_empty_n_q, rsp_err_q;
    logic          ph_start, ph_done;
    logic          accept, capture, cmd_illegal;
    logic [LW-1:0] level_cap;
    logic          peek_oob, sync_bad, echo_bad;

    fifo_host_phase_cnt #(.HALF_PER(HALF_PER)) u_phase (
        .clk   (clk),
        .reset (reset),
        .start (ph_start),
        .done  (ph_done)
    );

    assign cmd_illegal = (op_e'(host.cmd_op) == OP_PUSH && level == LW'(DEPTH)) ||
                         (op_e'(host.cmd_op) == OP_POP  && level == '0);

    always_comb begin
        state_d  = state_q;
        ph_start = 1'b0;
        accept   = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_RST: begin
                state_d  = ST_INIT;
                ph_start = 1'b1;
            end
            ST_INIT: if (ph_done) begin
                state_d  = ST_INIT_HI;
                ph_start = 1'b1;
            end
            ST_INIT_HI: if (ph_done) state_d = ST_IDLE;
            ST_IDLE: if (host.cmd_valid) begin
                accept = 1'b1;
                if (cmd_illegal) begin
                    state_d = ST_RESP;
                end else begin
                    state_d  = ST_SETUP;
                    ph_start = 1'b1;
                end
            end
            ST_SETUP: if (ph_done) begin
                state_d  = ST_HIGH;
                ph_start = 1'b1;
            end
            ST_HIGH: if (ph_done) begin
                state_d = ST_RESP;
                capture = 1'b1;
            end
            ST_RESP: if (host.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_RST;
        endcase
    end

    always_comb begin
        level_cap = level;
        case (op_q)
            OP_PUSH:      level_cap = level + LW'(1);
            OP_POP:       level_cap = level - LW'(1);
            OP_DEV_RESET: level_cap = '0;
            default:      level_cap = level;
        endcase
    end

    assign peek_oob = (op_q == OP_PEEK) && (LW'(peek_q) >= level);
    assign sync_bad = dev_io_out[PIN_MODE] != (level_cap != '0);

`ifdef FIFO_HOST_ECHO_CHECK_EN
    assign echo_bad = dev_io_out[PIN_CLK];
`else
    logic unused_echo;
    assign unused_echo = dev_io_out[PIN_CLK];
    assign echo_bad    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RST;
            op_q          <= OP_DEV_RESET;
            data_q        <= '0;
            peek_q        <= '0;
            rsp_data_q    <= '0;
            rsp_empty_n_q <= 1'b0;
            rsp_err_q     <= 1'b0;
            level         <= '0;
            desync        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op_e'(host.cmd_op);
                data_q <= host.cmd_data;
                peek_q <= host.cmd_peek;
                if (cmd_illegal) begin
                    rsp_data_q    <= '0;
                    rsp_empty_n_q <= 1'b0;
                    rsp_err_q     <= 1'b1;
                end
            end
            if (capture) begin
                rsp_data_q    <= dev_io_out[7:2];
                rsp_empty_n_q <= dev_io_out[PIN_MODE];
                rsp_err_q     <= peek_oob | sync_bad | echo_bad;
                level         <= level_cap;
                // A fresh mismatch wins over the clear a DEV_RESET would otherwise give.
                if (sync_bad || echo_bad)    desync <= 1'b1;
                else if (op_q == OP_DEV_RESET) desync <= 1'b0;
            end
        end
    end

    always_comb begin
        dev_io_in = PAT_IDLE;
        case (state_q)
            ST_INIT, ST_INIT_HI: dev_io_in = PAT_RESET;
            ST_SETUP, ST_HIGH:   dev_io_in = op_pattern(op_q, data_q, peek_q);
            default:             dev_io_in = PAT_IDLE;
        endcase
        if (state_q == ST_INIT_HI || state_q == ST_HIGH) dev_io_in[PIN_CLK] = 1'b1;
    end

    assign host.cmd_ready   = (state_q == ST_IDLE);
    assign host.rsp_valid   = (state_q == ST_RESP);
    assign host.rsp_data    = rsp_data_q;
    assign host.rsp_empty_n = rsp_empty_n_q;
    assign host.rsp_err     = rsp_err_q;
endmodule

// File: tb/tb_fifo_pin_host.sv
// Bench for fifo_pin_host paired with a behavioural pin-level FIFO device.
module tb_fifo_pin_host;
    import fifo_host_pkg::*;

    localparam int HP      = 2;
    localparam int DEV_LAT = 2 * HP + 1;

    typedef struct {
        bit         err;
        bit         en;
        logic [5:0] data;
        bit         chk_en;
        bit         chk_data;
        int         lat;
        logic [4:0] lvl;
        int         edges;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [4:0] level;
    logic       desync;
    logic [7:0] dev_io_in;
    logic [7:0] dev_io_out;

    int   errors = 0;
    int   checks = 0;
    int   dev_edges = 0;
    int   rst_edges = 0;
    int   stable = 0;
    logic [7:1] prev_pins = 7'h02;
    logic prev_clk = 1'b0;
    exp_t sb[$];

    // device model state
    logic [5:0] dmem [16];
    logic [3:0] dhead;
    logic [4:0] dcnt;
    logic [5:0] dout;
    bit         force_empty = 1'b0;
    wire  [3:0] widx = dhead + dcnt[3:0];
    wire  [3:0] pidx = dhead + dev_io_in[7:4];

    fifo_pin_host_if #(.DW(6)) ifc ();

    fifo_pin_host #(.HALF_PER(HP), .DW(6), .DEPTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .host       (ifc),
        .level      (level),
        .desync     (desync),
        .dev_io_in  (dev_io_in),
        .dev_io_out (dev_io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge dev_io_in[0]) begin
        if (dev_io_in[1]) begin
            if (dcnt < 5'd16) begin
                dmem[widx] <= dev_io_in[7:2];
                dcnt       <= dcnt + 5'd1;
            end
        end else if (!dev_io_in[2]) begin
            dcnt  <= '0;
            dhead <= '0;
            dout  <= '0;
            for (int i = 0; i < 16; i++) dmem[i] <= '0;
        end else if (dev_io_in[3]) begin
            dout <= dmem[dhead];
            if (dcnt != 0) begin
                dhead <= dhead + 4'd1;
                dcnt  <= dcnt - 5'd1;
            end
        end else begin
            dout <= dmem[pidx];
        end
    end

    assign dev_io_out = {dout, force_empty ? 1'b0 : (dcnt != 0), ~dev_io_in[0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pin monitor: every device clock rise must follow HP stable cycles of the other pins.
    always @(negedge clk) begin
        if (dev_io_in[7:1] != prev_pins) stable = 0;
        else                             stable++;
        if (dev_io_in[0] && !prev_clk) begin
            dev_edges++;
            if (dev_io_in[2:1] == 2'b00) rst_edges++;
            chk("pin_setup", 32'(stable >= HP), 1);
        end
        prev_pins = dev_io_in[7:1];
        prev_clk  = dev_io_in[0];
    end

    function automatic exp_t mk(bit err, bit en, logic [5:0] data, bit chk_en, bit chk_data,
                                int lat, logic [4:0] lvl, int edges);
        exp_t e;
        e.err = err; e.en = en; e.data = data; e.chk_en = chk_en; e.chk_data = chk_data;
        e.lat = lat; e.lvl = lvl; e.edges = edges;
        return e;
    endfunction

    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [5:0] d,
                          input logic [3:0] pk, input exp_t e);
        exp_t got;
        int   n;
        int   lat;
        int   e0;
        bit   seen;
        sb.push_back(e);
        @(negedge clk);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_data  = d;
        ifc.cmd_peek  = pk;
        n = 0;
        while (!ifc.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/ready"}, 32'(ifc.cmd_ready), 1);
        e0 = dev_edges;
        @(posedge clk);
        #1 ifc.cmd_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            seen = ifc.rsp_valid;
        end
        chk({tag, "/rsp_seen"}, 32'(seen), 1);
        got = sb.pop_front();
        chk({tag, "/latency"}, lat, got.lat);
        chk({tag, "/err"}, 32'(ifc.rsp_err), 32'(got.err));
        if (got.chk_en)   chk({tag, "/empty_n"}, 32'(ifc.rsp_empty_n), 32'(got.en));
        if (got.chk_data) chk({tag, "/data"}, 32'(ifc.rsp_data), 32'(got.data));
        chk({tag, "/level"}, 32'(level), 32'(got.lvl));
        @(negedge clk);
        chk({tag, "/hold"}, 32'(ifc.rsp_valid), 1);
        chk({tag, "/edges"}, dev_edges - e0, got.edges);
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        #1 ifc.rsp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit saw_rsp;
        reset         = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = 2'd0;
        ifc.cmd_data  = '0;
        ifc.cmd_peek  = '0;
        ifc.rsp_ready = 1'b0;

        repeat (4) @(negedge clk);
        chk("rst_pins", 32'(dev_io_in), 32'h04);
        chk("rst_cmd_ready", 32'(ifc.cmd_ready), 0);
        chk("rst_rsp_valid", 32'(ifc.rsp_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_desync", 32'(desync), 0);
        rst_edges = 0;
        reset = 1'b0;
        n = 0;
        while (!ifc.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("init_ready", 32'(ifc.cmd_ready), 1);
        chk("init_reset_edges", rst_edges, 1);
        chk("init_level", 32'(level), 0);
        chk("init_rsp_valid", 32'(ifc.rsp_valid), 0);
        chk("init_pins_idle", 32'(dev_io_in), 32'h04);

        do_cmd("push_2a", OP_PUSH, 6'h2A, 4'd0, mk(0, 1, 6'h00, 1, 0, DEV_LAT, 5'd1, 1));
        do_cmd("push_15", OP_PUSH, 6'h15, 4'd0, mk(0, 1, 6'h00, 1, 0, DEV_LAT, 5'd2, 1));
        do_cmd("peek_1",  OP_PEEK, 6'h00, 4'd1, mk(0, 1, 6'h15, 1, 1, DEV_LAT, 5'd2, 1));
        do_cmd("pop_2a",  OP_POP,  6'h00, 4'd0, mk(0, 1, 6'h2A, 1, 1, DEV_LAT, 5'd1, 1));
        do_cmd("pop_15",  OP_POP,  6'h00, 4'd0, mk(0, 0, 6'h15, 1, 1, DEV_LAT, 5'd0, 1));
        do_cmd("pop_empty", OP_POP, 6'h00, 4'd0, mk(1, 0, 6'h00, 0, 1, 1, 5'd0, 0));

        for (int i = 0; i < 17; i++) begin
            if (i < 16) do_cmd("push_fill", OP_PUSH, 6'(i), 4'd0, mk(0, 1, 6'h00, 1, 0, DEV_LAT, 5'(i + 1), 1));
            else        do_cmd("push_full", OP_PUSH, 6'(i), 4'd0, mk(1, 0, 6'h00, 0, 1, 1, 5'd16, 0));
        end
        for (int i = 0; i < 16; i++)
            do_cmd("pop_drain", OP_POP, 6'h00, 4'd0, mk(0, i != 15, 6'(i), 1, 1, DEV_LAT, 5'(15 - i), 1));

        do_cmd("push_d1", OP_PUSH, 6'd1, 4'd0, mk(0, 1, 6'h00, 1, 0, DEV_LAT, 5'd1, 1));
        do_cmd("push_d2", OP_PUSH, 6'd2, 4'd0, mk(0, 1, 6'h00, 1, 0, DEV_LAT, 5'd2, 1));
        do_cmd("push_d3", OP_PUSH, 6'd3, 4'd0, mk(0, 1, 6'h00, 1, 0, DEV_LAT, 5'd3, 1));
        chk("desync_before", 32'(desync), 0);
        force_empty = 1'b1;
        do_cmd("peek_desync", OP_PEEK, 6'h00, 4'd0, mk(1, 0, 6'd1, 1, 1, DEV_LAT, 5'd3, 1));
        chk("desync_set", 32'(desync), 1);
        force_empty = 1'b0;
        do_cmd("dev_reset", OP_DEV_RESET, 6'h00, 4'd0, mk(0, 0, 6'h00, 1, 0, DEV_LAT, 5'd0, 1));
        chk("desync_cleared", 32'(desync), 0);

        // reset lands while the device clock is high during a PUSH
        @(negedge clk);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = OP_PUSH;
        ifc.cmd_data  = 6'h33;
        n = 0;
        while (!ifc.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 ifc.cmd_valid = 1'b0;
        repeat (HP + 1) @(negedge clk);
        chk("midop_clk_high", 32'(dev_io_in[0]), 1);
        reset     = 1'b1;
        rst_edges = 0;
        repeat (2) @(negedge clk);
        chk("midop_rst_rsp_valid", 32'(ifc.rsp_valid), 0);
        chk("midop_rst_pins", 32'(dev_io_in), 32'h04);
        reset   = 1'b0;
        saw_rsp = 1'b0;
        n = 0;
        while (!ifc.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
            if (ifc.rsp_valid) saw_rsp = 1'b1;
        end
        chk("midop_ready", 32'(ifc.cmd_ready), 1);
        chk("midop_no_rsp", 32'(saw_rsp), 0);
        chk("midop_reset_edges", rst_edges, 1);
        chk("midop_level", 32'(level), 0);
        do_cmd("peek_after_rst", OP_PEEK, 6'h00, 4'd0, mk(1, 0, 6'h00, 1, 1, DEV_LAT, 5'd0, 1));

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
